// File: rtl/coef_pkg.sv
// coef_pkg: shared types and the table-generation function for coef_seq.
//   state_t   : sequencer states IDLE / RUN / DONE
//   mode_t    : table select, EVEN series or ODD series
//   coef_calc : elaboration-time table entry generator
package coef_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_EVEN = 1'b0,
        MODE_ODD  = 1'b1
    } mode_t;

    // EVEN entry k = floor(2^W / ((2k+1)(2k+2))),
    // ODD entry k  = floor(2^W / ((2k+2)(2k+3))).
    // Only ever called with constant arguments, so it folds away at elaboration.
    function automatic int coef_calc(input logic odd, input int k, input int data_w);
        int num;
        int den;
        num = 32'sd1 << data_w;
        if (odd) begin
            den = (32'sd2 * k + 32'sd2) * (32'sd2 * k + 32'sd3);
        end else begin
            den = (32'sd2 * k + 32'sd1) * (32'sd2 * k + 32'sd2);
        end
        return num / den;
    endfunction

endpackage

// File: rtl/coef_rom.sv
// coef_rom: combinational lookup of both coefficient tables.
//   mode : table select (EVEN / ODD)
//   idx  : term index k
//   coef : table entry for (mode, idx)
module coef_rom
    import coef_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int N_TERMS = 8,
    localparam int IDX_W   = $clog2(N_TERMS)
) (
    input  mode_t              mode,
    input  logic [IDX_W-1:0]   idx,
    output logic [DATA_W-1:0]  coef
);

    // Tables are padded to a power of two so every idx value selects a
    // defined (zero) entry even when N_TERMS is not a power of two.
    localparam int DEPTH = 32'sd1 << IDX_W;

    logic [DATA_W-1:0] even_tab [DEPTH];
    logic [DATA_W-1:0] odd_tab  [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        localparam int EV = (k < N_TERMS) ? coef_calc(1'b0, k, DATA_W) : 32'sd0;
        localparam int OD = (k < N_TERMS) ? coef_calc(1'b1, k, DATA_W) : 32'sd0;
        assign even_tab[k] = DATA_W'(EV);
        assign odd_tab[k]  = DATA_W'(OD);
    end

    // Table select and index.
    always_comb begin
        if (mode == MODE_ODD) begin
            coef = odd_tab[idx];
        end else begin
            coef = even_tab[idx];
        end
    end

endmodule

// File: rtl/coef_seq.sv
// coef_seq: emits a burst of series coefficients over a valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   start    : burst request, sampled in IDLE only
//   mode     : 0 = EVEN series, 1 = ODD series (latched on accepted start)
//   len      : number of terms, clamped to N_TERMS (latched on accepted start)
//   abort    : ends any burst in progress, no done pulse
//   ready    : consumer accept
//   valid, coef, idx, last : registered beat outputs
//   busy     : state is not IDLE
//   done     : one-cycle pulse on normal completion
module coef_seq
    import coef_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int N_TERMS = 8,
    localparam int IDX_W   = $clog2(N_TERMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [IDX_W:0]     len,
    input  logic               abort,
    input  logic               ready,
    output logic               valid,
    output logic [DATA_W-1:0]  coef,
    output logic [IDX_W-1:0]   idx,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W:0] MAX_LEN = (IDX_W + 1)'(N_TERMS);

    state_t             state_r;
    state_t             state_nxt;
    mode_t              mode_r;
    mode_t              mode_nxt;
    logic [IDX_W:0]     len_r;
    logic [IDX_W:0]     len_nxt;
    logic [IDX_W:0]     eff_len_s;
    logic [IDX_W-1:0]   idx_nxt;
    logic               valid_nxt;
    logic               last_nxt;
    logic               done_nxt;
    logic               busy_nxt;
    logic [DATA_W-1:0]  rom_coef_s;
    logic [DATA_W-1:0]  coef_nxt;

    // The ROM looks up the entry for the *next* index so coef can be
    // registered alongside idx on the same edge.
    coef_rom #(
        .DATA_W  (DATA_W),
        .N_TERMS (N_TERMS)
    ) u_rom (
        .mode (mode_nxt),
        .idx  (idx_nxt),
        .coef (rom_coef_s)
    );

    // coef only changes when a beat is being presented; otherwise it holds.
    assign coef_nxt = valid_nxt ? rom_coef_s : coef;

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state_r;
        mode_nxt  = mode_r;
        len_nxt   = len_r;
        idx_nxt   = idx;
        valid_nxt = valid;
        last_nxt  = last;
        done_nxt  = 1'b0;

        if (len > MAX_LEN) begin
            eff_len_s = MAX_LEN;
        end else begin
            eff_len_s = len;
        end

        case (state_r)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (start && !abort) begin
                    mode_nxt = mode_t'(mode);
                    len_nxt  = eff_len_s;
                    idx_nxt  = '0;
                    if (eff_len_s == (IDX_W + 1)'(0)) begin
                        // Empty burst: straight to completion, no beat.
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                        valid_nxt = 1'b1;
                        last_nxt  = (eff_len_s == (IDX_W + 1)'(1));
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end else if (valid && ready) begin
                    if (last) begin
                        state_nxt = ST_DONE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt  = idx + IDX_W'(1);
                        // idx+1 == len-1, written without underflow
                        last_nxt = (({1'b0, idx} + (IDX_W + 1)'(2)) == len_r);
                    end
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                // done is already high this cycle; abort or not, go idle.
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_EVEN;
            len_r   <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            last    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            coef    <= '0;
        end else begin
            state_r <= state_nxt;
            mode_r  <= mode_nxt;
            len_r   <= len_nxt;
            idx     <= idx_nxt;
            valid   <= valid_nxt;
            last    <= last_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
            coef    <= coef_nxt;
        end
    end

endmodule

// File: tb/tb_coef_seq.sv
// tb_coef_seq: directed self-checking bench for coef_seq (DATA_W=8, N_TERMS=8).
module tb_coef_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] len;
    logic       abort;
    logic       ready;
    logic       valid;
    logic [7:0] coef;
    logic [2:0] idx;
    logic       last;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] even_exp [8] = '{8'h80, 8'h15, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01, 8'h01};
    logic [7:0] odd_exp  [3] = '{8'h2A, 8'h0C, 8'h06};

    coef_seq #(.DATA_W(8), .N_TERMS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .len   (len),
        .abort (abort),
        .ready (ready),
        .valid (valid),
        .coef  (coef),
        .idx   (idx),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] k, input logic [7:0] c,
                            input logic l);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_idx"},   32'(idx),   32'(k));
        chk({tag, "_coef"},  32'(coef),  32'(c));
        chk({tag, "_last"},  32'(last),  32'(l));
    endtask

    initial begin
        int  beats;
        logic saw_done;

        rst = 1'b1; start = 1'b0; mode = 1'b0; len = 4'd0; abort = 1'b0; ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_coef",  32'(coef),  32'd0);
        chk("rst_idx",   32'(idx),   32'd0);
        chk("rst_last",  32'(last),  32'd0);
        rst = 1'b0;
        tick();

        // Full EVEN burst, ready constant; mode/len changed after start, start
        // re-pulsed mid-burst: none of it may disturb the burst.
        mode = 1'b0; len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0; mode = 1'b1; len = 4'd2;
        for (int k = 0; k < 8; k++) begin
            chk_beat("even", 3'(k), even_exp[k], (k == 7));
            chk("even_done_low", 32'(done), 32'd0);
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        chk("even_done", 32'(done), 32'd1);
        chk("even_valid_off", 32'(valid), 32'd0);
        tick();
        chk("even_done_pulse", 32'(done), 32'd0);
        chk("even_busy_off", 32'(busy), 32'd0);

        // ODD burst with ready toggling 1,0: beats hold through ready=0.
        mode = 1'b1; len = 4'd3; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_beat("odd", 3'(k), odd_exp[k], (k == 2));
            ready = 1'b0;
            tick();
            chk_beat("odd_hold", 3'(k), odd_exp[k], (k == 2));
            ready = 1'b1;
            tick();
        end
        chk("odd_done", 32'(done), 32'd1);
        tick();
        chk("odd_done_pulse", 32'(done), 32'd0);

        // len=0: no beat, busy one cycle, done pulse.
        mode = 1'b0; len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_valid", 32'(valid), 32'd0);
        chk("len0_busy",  32'(busy),  32'd1);
        chk("len0_done",  32'(done),  32'd1);
        tick();
        chk("len0_busy_off", 32'(busy), 32'd0);
        chk("len0_done_off", 32'(done), 32'd0);

        // Start in the cycle right after done; len=12 clamps to 8 beats.
        len = 4'd12; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_coef",  32'(coef),  32'h80);
        beats = 0;
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (valid) beats++;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            tick();
        end
        chk("clamp_beats", 32'(beats), 32'd8);
        chk("clamp_done",  32'(saw_done), 32'd1);
        tick();

        // abort beats start in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_idle_busy",  32'(busy),  32'd0);
        chk("abort_idle_valid", 32'(valid), 32'd0);

        // abort at idx=3 with ready=1.
        len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk_beat("pre_abort", 3'd3, 8'h04, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("post_abort0", 3'd0, 8'h80, 1'b0);
        tick();
        chk_beat("post_abort1", 3'd1, 8'h15, 1'b1);
        tick();
        chk("post_abort_done", 32'(done), 32'd1);
        tick();

        // Reset at idx=5 mid-burst.
        len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        chk_beat("pre_rst", 3'd5, 8'h01, 1'b0);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_last",  32'(last),  32'd0);
        chk("mrst_busy",  32'(busy),  32'd0);
        chk("mrst_done",  32'(done),  32'd0);
        chk("mrst_coef",  32'(coef),  32'd0);
        chk("mrst_idx",   32'(idx),   32'd0);
        tick();
        chk("mrst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
